// File: rtl/bloom_filter_pkg.sv
// Shared widths and the LUT write-port controller state type for the bloom filter slice.
package bloom_filter_pkg;

  localparam int BYTE_W         = 8;
  localparam int AMM_LUT_ADDR_W = 18;
  localparam int AMM_LUT_DATA_W = BYTE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } lut_ctrl_state_t;

endpackage

// File: rtl/bloom_lut_clear_seq.sv
// Address counter for the LUT clear sweep.
// It flags when every address has been handed out.
module bloom_lut_clear_seq #(
  parameter int ADDR_W = 18,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_busy,
  output logic              o_last,
  output logic [ADDR_W-1:0] o_addr
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

  // Address 0 is issued by the parent on the start cycle, so the count begins at 1.
  // One extra bit lets a full-depth sweep reach DEPTH without wrapping.
  logic [ADDR_W:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= LP_ONE;
    end else if (i_busy && !o_last) begin
      r_cnt <= r_cnt + LP_ONE;
    end
  end

  assign o_last = (r_cnt == LP_DEPTH);
  assign o_addr = r_cnt[ADDR_W-1:0];

endmodule

// File: rtl/bloom_lut_ctrl.sv
// Owns the bloom filter LUT write port.
// It arbitrates host Avalon-MM writes against a full-table clear sweep.
module bloom_lut_ctrl #(
  parameter int AMM_LUT_ADDR_W = bloom_filter_pkg::AMM_LUT_ADDR_W,
  parameter int AMM_LUT_DATA_W = bloom_filter_pkg::AMM_LUT_DATA_W,
  parameter int LUT_DEPTH      = 2**AMM_LUT_ADDR_W,
  parameter int WR_CNT_W       = 16
) (
  input  logic                      main_clk_i,
  input  logic                      main_arst_i,
  input  logic [AMM_LUT_ADDR_W-1:0] host_lut_address_i,
  input  logic                      host_lut_write_i,
  input  logic [AMM_LUT_DATA_W-1:0] host_lut_writedata_i,
  output logic                      host_lut_waitrequest_o,
  input  logic                      clear_start_i,
  input  logic [AMM_LUT_DATA_W-1:0] clear_value_i,
  output logic                      clear_busy_o,
  output logic                      clear_done_o,
  output logic                      hold_traffic_o,
  output logic [WR_CNT_W-1:0]       host_wr_cnt_o,
  output logic [AMM_LUT_ADDR_W-1:0] lut_address_o,
  output logic                      lut_write_o,
  output logic [AMM_LUT_DATA_W-1:0] lut_writedata_o
);

  import bloom_filter_pkg::*;

  localparam logic [WR_CNT_W-1:0] LP_CNT_ONE = WR_CNT_W'(1);

  lut_ctrl_state_t r_state;
  lut_ctrl_state_t w_next_state;

  logic                      w_start_acc;
  logic                      w_host_acc;
  logic                      w_seq_last;
  logic [AMM_LUT_ADDR_W-1:0] w_seq_addr;
  logic                      w_waitrequest;
  logic                      w_done;
  logic                      w_lut_write;
  logic [AMM_LUT_ADDR_W-1:0] w_lut_address;
  logic [AMM_LUT_DATA_W-1:0] w_lut_writedata;

  logic [AMM_LUT_DATA_W-1:0] r_fill;
  logic                      r_busy;
  logic                      r_hold;
  logic [WR_CNT_W-1:0]       r_wr_cnt;
  logic                      r_lut_write;
  logic [AMM_LUT_ADDR_W-1:0] r_lut_address;
  logic [AMM_LUT_DATA_W-1:0] r_lut_writedata;

  bloom_lut_clear_seq #(
    .ADDR_W (AMM_LUT_ADDR_W),
    .DEPTH  (LUT_DEPTH)
  ) u_clear_seq (
    .i_clk   (main_clk_i),
    .i_rst   (main_arst_i),
    .i_start (w_start_acc),
    .i_busy  (r_state == CLEAR),
    .o_last  (w_seq_last),
    .o_addr  (w_seq_addr)
  );

  always_ff @(posedge main_clk_i or posedge main_arst_i) begin
    if (main_arst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (clear_start_i) w_next_state = CLEAR;
      CLEAR:   if (w_seq_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // A clear start wins over a same-cycle host write; that write stays stalled until IDLE.
  always_comb begin
    w_waitrequest   = 1'b1;
    w_done          = 1'b0;
    w_start_acc     = 1'b0;
    w_host_acc      = 1'b0;
    w_lut_write     = 1'b0;
    w_lut_address   = r_lut_address;
    w_lut_writedata = r_lut_writedata;
    case (r_state)
      IDLE: begin
        w_waitrequest = clear_start_i;
        if (clear_start_i) begin
          w_start_acc     = 1'b1;
          w_lut_write     = 1'b1;
          w_lut_address   = '0;
          w_lut_writedata = clear_value_i;
        end else if (host_lut_write_i) begin
          w_host_acc      = 1'b1;
          w_lut_write     = 1'b1;
          w_lut_address   = host_lut_address_i;
          w_lut_writedata = host_lut_writedata_i;
        end
      end
      CLEAR: begin
        if (!w_seq_last) begin
          w_lut_write     = 1'b1;
          w_lut_address   = w_seq_addr;
          w_lut_writedata = r_fill;
        end
      end
      DONE:    w_done = 1'b1;
      default: w_done = 1'b0;
    endcase
  end

  always_ff @(posedge main_clk_i or posedge main_arst_i) begin
    if (main_arst_i) begin
      r_fill          <= '0;
      r_busy          <= 1'b0;
      r_hold          <= 1'b0;
      r_wr_cnt        <= '0;
      r_lut_write     <= 1'b0;
      r_lut_address   <= '0;
      r_lut_writedata <= '0;
    end else begin
      if (w_start_acc) r_fill <= clear_value_i;
      r_busy          <= (w_next_state == CLEAR);
      r_hold          <= (w_next_state != IDLE);
      if (w_host_acc && (r_wr_cnt != '1)) r_wr_cnt <= r_wr_cnt + LP_CNT_ONE;
      r_lut_write     <= w_lut_write;
      r_lut_address   <= w_lut_address;
      r_lut_writedata <= w_lut_writedata;
    end
  end

  assign host_lut_waitrequest_o = w_waitrequest;
  assign clear_busy_o           = r_busy;
  assign clear_done_o           = w_done;
  assign hold_traffic_o         = r_hold;
  assign host_wr_cnt_o          = r_wr_cnt;
  assign lut_address_o          = r_lut_address;
  assign lut_write_o            = r_lut_write;
  assign lut_writedata_o        = r_lut_writedata;

endmodule

// File: tb/tb_bloom_lut_ctrl.sv
// Directed bench for bloom_lut_ctrl with a 16-word sweep and a 2-bit host write counter.
// Every check is a hand-computed expectation.
module tb_bloom_lut_ctrl;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [DATA_W-1:0] hdata;
  logic              hwait;
  logic              cstart;
  logic [DATA_W-1:0] cval;
  logic              busy;
  logic              done;
  logic              hold;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] laddr;
  logic              lwrite;
  logic [DATA_W-1:0] ldata;

  int checks   = 0;
  int failures = 0;
  int expCnt [5] = '{1, 2, 3, 3, 3};

  always #5 clk = ~clk;

  bloom_lut_ctrl #(
    .AMM_LUT_ADDR_W (ADDR_W),
    .AMM_LUT_DATA_W (DATA_W),
    .LUT_DEPTH      (DEPTH),
    .WR_CNT_W       (CNT_W)
  ) dut (
    .main_clk_i             (clk),
    .main_arst_i            (rst),
    .host_lut_address_i     (haddr),
    .host_lut_write_i       (hwrite),
    .host_lut_writedata_i   (hdata),
    .host_lut_waitrequest_o (hwait),
    .clear_start_i          (cstart),
    .clear_value_i          (cval),
    .clear_busy_o           (busy),
    .clear_done_o           (done),
    .hold_traffic_o         (hold),
    .host_wr_cnt_o          (cnt),
    .lut_address_o          (laddr),
    .lut_write_o            (lwrite),
    .lut_writedata_o        (ldata)
  );

  task automatic applyStimulus(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input logic s, input logic [DATA_W-1:0] v);
    hwrite = w;
    haddr  = a;
    hdata  = d;
    cstart = s;
    cval   = v;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    #12;
    checkOutput("rst_lwrite", 32'(lwrite), 0);
    checkOutput("rst_laddr",  32'(laddr),  0);
    checkOutput("rst_ldata",  32'(ldata),  0);
    checkOutput("rst_busy",   32'(busy),   0);
    checkOutput("rst_done",   32'(done),   0);
    checkOutput("rst_hold",   32'(hold),   0);
    checkOutput("rst_cnt",    32'(cnt),    0);
    checkOutput("rst_hwait",  32'(hwait),  0);
    rst = 1'b0;
    stepClock();

    $display("[TB] host writes back-to-back");
    applyStimulus(1'b1, 18'd5, 8'hA5, 1'b0, 8'h00);
    #1;
    checkOutput("h1_hwait", 32'(hwait), 0);
    stepClock();
    checkOutput("h1_lwrite", 32'(lwrite), 1);
    checkOutput("h1_laddr",  32'(laddr),  5);
    checkOutput("h1_ldata",  32'(ldata),  'hA5);
    checkOutput("h1_cnt",    32'(cnt),    1);
    applyStimulus(1'b1, 18'd6, 8'h3C, 1'b0, 8'h00);
    stepClock();
    checkOutput("h2_lwrite", 32'(lwrite), 1);
    checkOutput("h2_laddr",  32'(laddr),  6);
    checkOutput("h2_ldata",  32'(ldata),  'h3C);
    checkOutput("h2_cnt",    32'(cnt),    2);
    applyStimulus(1'b0, 18'd0, 8'h00, 1'b0, 8'h00);
    stepClock();
    checkOutput("h_idle_lwrite", 32'(lwrite), 0);
    checkOutput("h_idle_laddr",  32'(laddr),  6);
    checkOutput("h_idle_ldata",  32'(ldata),  'h3C);

    $display("[TB] clear sweep with fill 0x00");
    applyStimulus(1'b0, 18'd0, 8'h00, 1'b1, 8'h00);
    #1;
    checkOutput("c1_start_hwait", 32'(hwait), 1);
    stepClock();
    applyStimulus(1'b0, 18'd0, 8'h00, 1'b0, 8'hFF);
    for (int k = 0; k < DEPTH; k++) begin
      checkOutput("c1_lwrite", 32'(lwrite), 1);
      checkOutput("c1_laddr",  32'(laddr),  k);
      checkOutput("c1_ldata",  32'(ldata),  0);
      checkOutput("c1_busy",   32'(busy),   1);
      checkOutput("c1_hold",   32'(hold),   1);
      checkOutput("c1_done",   32'(done),   0);
      checkOutput("c1_hwait",  32'(hwait),  1);
      stepClock();
    end
    checkOutput("c1_done_pulse", 32'(done),   1);
    checkOutput("c1_done_busy",  32'(busy),   0);
    checkOutput("c1_done_hold",  32'(hold),   1);
    checkOutput("c1_done_write", 32'(lwrite), 0);
    checkOutput("c1_done_hwait", 32'(hwait),  1);
    checkOutput("c1_done_laddr", 32'(laddr),  15);
    stepClock();
    checkOutput("c1_post_done",  32'(done),  0);
    checkOutput("c1_post_hold",  32'(hold),  0);
    checkOutput("c1_post_hwait", 32'(hwait), 0);
    checkOutput("c1_post_cnt",   32'(cnt),   2);

    $display("[TB] clear start collides with host write");
    applyStimulus(1'b1, 18'd3, 8'h77, 1'b1, 8'h5A);
    #1;
    checkOutput("c2_start_hwait", 32'(hwait), 1);
    stepClock();
    applyStimulus(1'b1, 18'd3, 8'h77, 1'b0, 8'hEE);
    for (int k = 0; k < DEPTH; k++) begin
      checkOutput("c2_lwrite", 32'(lwrite), 1);
      checkOutput("c2_laddr",  32'(laddr),  k);
      checkOutput("c2_ldata",  32'(ldata),  'h5A);
      checkOutput("c2_hwait",  32'(hwait),  1);
      checkOutput("c2_cnt",    32'(cnt),    2);
      stepClock();
    end
    checkOutput("c2_done_pulse", 32'(done),   1);
    checkOutput("c2_done_write", 32'(lwrite), 0);
    checkOutput("c2_done_hwait", 32'(hwait),  1);
    stepClock();
    checkOutput("c2_idle_hwait", 32'(hwait),  0);
    checkOutput("c2_idle_write", 32'(lwrite), 0);
    checkOutput("c2_idle_cnt",   32'(cnt),    2);
    stepClock();
    checkOutput("c2_held_write", 32'(lwrite), 1);
    checkOutput("c2_held_laddr", 32'(laddr),  3);
    checkOutput("c2_held_ldata", 32'(ldata),  'h77);
    checkOutput("c2_held_cnt",   32'(cnt),    3);
    applyStimulus(1'b0, 18'd0, 8'h00, 1'b0, 8'h00);
    stepClock();

    $display("[TB] clear start re-pulsed mid-sweep");
    applyStimulus(1'b0, 18'd0, 8'h00, 1'b1, 8'hC3);
    stepClock();
    cstart = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      checkOutput("c3_lwrite", 32'(lwrite), 1);
      checkOutput("c3_laddr",  32'(laddr),  k);
      checkOutput("c3_ldata",  32'(ldata),  'hC3);
      cstart = (k == 5);
      stepClock();
    end
    checkOutput("c3_done_pulse", 32'(done),   1);
    checkOutput("c3_done_write", 32'(lwrite), 0);
    stepClock();
    checkOutput("c3_post_write", 32'(lwrite), 0);
    checkOutput("c3_post_busy",  32'(busy),   0);
    checkOutput("c3_post_done",  32'(done),   0);
    stepClock();
    checkOutput("c3_idle_busy",  32'(busy),   0);
    checkOutput("c3_idle_hold",  32'(hold),   0);

    $display("[TB] reset during sweep");
    applyStimulus(1'b0, 18'd0, 8'h00, 1'b1, 8'h11);
    stepClock();
    cstart = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checkOutput("c4_laddr", 32'(laddr), k);
      checkOutput("c4_ldata", 32'(ldata), 'h11);
      if (k < 7) stepClock();
    end
    rst = 1'b1;
    #1;
    checkOutput("c4_rst_lwrite", 32'(lwrite), 0);
    checkOutput("c4_rst_laddr",  32'(laddr),  0);
    checkOutput("c4_rst_ldata",  32'(ldata),  0);
    checkOutput("c4_rst_busy",   32'(busy),   0);
    checkOutput("c4_rst_hold",   32'(hold),   0);
    checkOutput("c4_rst_done",   32'(done),   0);
    checkOutput("c4_rst_cnt",    32'(cnt),    0);
    checkOutput("c4_rst_hwait",  32'(hwait),  0);
    stepClock();
    stepClock();
    checkOutput("c4_rst_hold_done", 32'(done), 0);
    rst = 1'b0;
    stepClock();
    checkOutput("c4_after_done", 32'(done), 0);
    checkOutput("c4_after_busy", 32'(busy), 0);
    applyStimulus(1'b0, 18'd0, 8'h00, 1'b1, 8'h22);
    stepClock();
    cstart = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      checkOutput("c5_laddr", 32'(laddr), k);
      checkOutput("c5_ldata", 32'(ldata), 'h22);
      stepClock();
    end
    checkOutput("c5_done_pulse", 32'(done), 1);
    stepClock();
    checkOutput("c5_post_hold", 32'(hold), 0);

    $display("[TB] host write counter saturation");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, ADDR_W'(100 + i), DATA_W'(i), 1'b0, 8'h00);
      stepClock();
      checkOutput("sat_lwrite", 32'(lwrite), 1);
      checkOutput("sat_laddr",  32'(laddr),  100 + i);
      checkOutput("sat_cnt",    32'(cnt),    expCnt[i]);
    end
    applyStimulus(1'b0, 18'd0, 8'h00, 1'b0, 8'h00);
    stepClock();
    checkOutput("sat_final_cnt", 32'(cnt),    3);
    checkOutput("sat_final_wr",  32'(lwrite), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
